// File: rtl/valve_sequencer.sv
// valve_sequencer: round-robin dwell/dead-time sequencer for a 4-way valve demux.
// Optional dead-time phase built when VALVE_SEQ_DEADTIME_EN is defined.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cfg_we/cfg_addr/cfg_data dwell register write port
//   run, abort, req         arbitration enable, sync kill, per-channel requests
//   dmx_in/enable/select    registered demux drive
//   grant_ch, busy          current/last grant, ACTIVE (or DEAD) flag
//   ch_done, ch_done_id     one-cycle completion pulse and its channel
module valve_sequencer #(
  parameter int DWELL_W     = 16,
  parameter int DEAD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [DWELL_W-1:0] cfg_data,
  input  logic               run,
  input  logic               abort,
  input  logic [3:0]         req,
  output logic               dmx_in,
  output logic               dmx_enable,
  output logic [3:0]         dmx_select,
  output logic [1:0]         grant_ch,
  output logic               busy,
  output logic               ch_done,
  output logic [1:0]         ch_done_id
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_dead_range
    $error("valve_sequencer: DEAD_CYCLES out of range 1..255");
  end

`ifdef VALVE_SEQ_DEADTIME_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DEAD
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE
  } state_t;
`endif

  state_t             r_state;
  logic [DWELL_W-1:0] r_dwell [4];
  logic [DWELL_W-1:0] r_cnt;
`ifdef VALVE_SEQ_DEADTIME_EN
  logic [7:0]         r_dead;
`endif
  logic [1:0]         r_rr_ptr;
  logic [1:0]         r_gch;
  logic               r_en;
  logic               r_in;
  logic [3:0]         r_sel;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         r_done_id;

  logic               w_hit;
  logic [1:0]         w_pick;
  logic [DWELL_W-1:0] w_dwell;
  logic [DWELL_W-1:0] w_load;

  // Highest offset first so the nearest requester
  // after rr_ptr is the one left standing.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_rr_ptr + 2'(i)]) begin
        w_hit  = 1'b1;
        w_pick = r_rr_ptr + 2'(i);
      end
    end
  end

  // Zero dwell still opens the valve for one cycle.
  assign w_dwell = r_dwell[w_pick];
  assign w_load  = (w_dwell == '0) ? DWELL_W'(1) : w_dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_dwell[i] <= DWELL_W'(1);
      end
      r_cnt     <= '0;
`ifdef VALVE_SEQ_DEADTIME_EN
      r_dead    <= '0;
`endif
      r_rr_ptr  <= '0;
      r_gch     <= '0;
      r_en      <= 1'b0;
      r_in      <= 1'b0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      // Config writes land even under abort; the
      // running count is a copy, so it is unaffected.
      if (cfg_we) begin
        r_dwell[cfg_addr] <= cfg_data;
      end
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
`ifdef VALVE_SEQ_DEADTIME_EN
        r_dead  <= '0;
`endif
        r_en    <= 1'b0;
        r_in    <= 1'b0;
        r_sel   <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (run && w_hit) begin
              r_state <= S_ACTIVE;
              r_gch   <= w_pick;
              r_cnt   <= w_load;
              r_en    <= 1'b1;
              r_in    <= 1'b1;
              r_sel   <= {2'b00, w_pick};
              r_busy  <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (r_cnt == DWELL_W'(1)) begin
              r_cnt     <= '0;
              r_en      <= 1'b0;
              r_in      <= 1'b0;
              r_done    <= 1'b1;
              r_done_id <= r_gch;
              r_rr_ptr  <= r_gch + 2'd1;
`ifdef VALVE_SEQ_DEADTIME_EN
              // select and busy hold through dead time
              r_state   <= S_DEAD;
              r_dead    <= 8'(DEAD_CYCLES);
`else
              r_state   <= S_IDLE;
              r_sel     <= '0;
              r_busy    <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt - DWELL_W'(1);
            end
          end
`ifdef VALVE_SEQ_DEADTIME_EN
          S_DEAD: begin
            if (r_dead == 8'd1) begin
              r_dead  <= '0;
              r_state <= S_IDLE;
              r_sel   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_dead <= r_dead - 8'd1;
            end
          end
`endif
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign dmx_in     = r_in;
  assign dmx_enable = r_en;
  assign dmx_select = r_sel;
  assign grant_ch   = r_gch;
  assign busy       = r_busy;
  assign ch_done    = r_done;
  assign ch_done_id = r_done_id;

endmodule

// File: tb/tb_valve_sequencer.sv
// tb_valve_sequencer: directed scenarios plus random traffic
// against a cycle-count reference model of the valve sequencer.
module tb_valve_sequencer;

  localparam int DC = 8;
`ifdef VALVE_SEQ_DEADTIME_EN
  localparam int DEADT = DC;
  localparam int GAP   = DC + 1;
`else
  localparam int DEADT = 0;
  localparam int GAP   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        run;
  logic        abort;
  logic [3:0]  req;
  logic        dmx_in;
  logic        dmx_enable;
  logic [3:0]  dmx_select;
  logic [1:0]  grant_ch;
  logic        busy;
  logic        ch_done;
  logic [1:0]  ch_done_id;

  valve_sequencer #(
    .DWELL_W    (16),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .run       (run),
    .abort     (abort),
    .req       (req),
    .dmx_in    (dmx_in),
    .dmx_enable(dmx_enable),
    .dmx_select(dmx_select),
    .grant_ch  (grant_ch),
    .busy      (busy),
    .ch_done   (ch_done),
    .ch_done_id(ch_done_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: open/dead remaining-cycle counts.
  int m_open, m_dead, m_ptr, m_gch, m_done, m_did;
  int m_dw [4];
  int nd   [4];
  bit found;

  // Event log of the valve as seen on the pins.
  int q_grant[$];
  int q_len[$];
  int q_gap[$];
  int q_done[$];
  int prev_en, open_n, closed_n, seen_close;

  function automatic int gr(int i);
    return (i < q_grant.size()) ? q_grant[i] : -1;
  endfunction
  function automatic int ln(int i);
    return (i < q_len.size()) ? q_len[i] : -1;
  endfunction
  function automatic int gp(int i);
    return (i < q_gap.size()) ? q_gap[i] : -1;
  endfunction
  function automatic int dn(int i);
    return (i < q_done.size()) ? q_done[i] : -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      // inputs seen here are the ones the last rising edge sampled
      if (!rst_n) begin
        m_open = 0; m_dead = 0; m_ptr = 0;
        m_gch = 0; m_done = 0; m_did = 0;
        for (int i = 0; i < 4; i++) m_dw[i] = 1;
      end else begin
        nd = m_dw;
        if (cfg_we) nd[cfg_addr] = int'(cfg_data);
        m_done = 0;
        if (abort) begin
          m_open = 0;
          m_dead = 0;
        end else if (m_open > 0) begin
          m_open--;
          if (m_open == 0) begin
            m_done = 1;
            m_did  = m_gch;
            m_ptr  = (m_gch + 1) % 4;
            m_dead = DEADT;
          end
        end else if (m_dead > 0) begin
          m_dead--;
        end else if (run && req != 0) begin
          found = 0;
          for (int k = 0; k < 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
              found = 1;
              m_gch = (m_ptr + k) % 4;
            end
          end
          m_open = (m_dw[m_gch] == 0) ? 1 : m_dw[m_gch];
        end
        m_dw = nd;
      end
      chk("enable", dmx_enable, m_open > 0);
      chk("in", dmx_in, m_open > 0);
      chk("busy", busy, (m_open > 0) || (m_dead > 0));
      chk("select", dmx_select,
          ((m_open > 0) || (m_dead > 0)) ? m_gch : 0);
      chk("grant_ch", grant_ch, m_gch);
      chk("ch_done", ch_done, m_done);
      if (m_done) chk("ch_done_id", ch_done_id, m_did);

      if (!rst_n) begin
        prev_en = 0; open_n = 0;
      end else begin
        if (ch_done) q_done.push_back(int'(ch_done_id));
        if (dmx_enable) begin
          if (!prev_en) begin
            q_grant.push_back(int'(grant_ch));
            if (seen_close) q_gap.push_back(closed_n);
          end
          open_n++;
        end else begin
          if (prev_en) begin
            q_len.push_back(open_n);
            open_n = 0; closed_n = 0; seen_close = 1;
          end
          closed_n++;
        end
        prev_en = int'(dmx_enable);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    q_grant.delete(); q_len.delete();
    q_gap.delete(); q_done.delete();
    seen_close = 0; closed_n = 0; open_n = 0;
  endtask

  task automatic cfg(int a, int d);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 16'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_len(int n, int budget);
    for (int t = 0; t < budget && q_len.size() < n; t++) tick();
    chk("wait_len budget", q_len.size() >= n, 1);
  endtask

  task automatic wait_grant(int n, int budget);
    for (int t = 0; t < budget && q_grant.size() < n; t++) tick();
    chk("wait_grant budget", q_grant.size() >= n, 1);
  endtask

  task automatic wait_done(int n, int budget);
    for (int t = 0; t < budget && q_done.size() < n; t++) tick();
    chk("wait_done budget", q_done.size() >= n, 1);
  endtask

  task automatic settle();
    run = 1'b0; req = 4'b0000;
    repeat (DC + 6) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    run = 1'b1; abort = 1'b0; req = 4'b0001;
    prev_en = 0; open_n = 0; closed_n = 0; seen_close = 0;

    // reset and default dwell of 1
    repeat (3) begin
      tick();
      chk("rst enable", dmx_enable, 0);
      chk("rst busy", busy, 0);
      chk("rst select", dmx_select, 0);
      chk("rst done", ch_done, 0);
    end
    clr();
    rst_n = 1'b1;
    wait_len(1, 30);
    chk("t1 grant", gr(0), 0);
    chk("t1 len", ln(0), 1);
    chk("t1 done id", dn(0), 0);
    settle();

    // dwell 5 on channel 2, gap to the next grant
    cfg(2, 5);
    clr();
    req = 4'b0100; run = 1'b1;
    wait_len(2, 60);
    chk("t2 grant", gr(0), 2);
    chk("t2 len0", ln(0), 5);
    chk("t2 len1", ln(1), 5);
    chk("t2 gap", gp(0), GAP);
    settle();

    // round robin with all dwells 2
    do_reset();
    for (int c = 0; c < 4; c++) cfg(c, 2);
    clr();
    req = 4'b1111; run = 1'b1;
    wait_len(5, 120);
    chk("t3 g0", gr(0), 0);
    chk("t3 g1", gr(1), 1);
    chk("t3 g2", gr(2), 2);
    chk("t3 g3", gr(3), 3);
    chk("t3 g4", gr(4), 0);
    for (int i = 0; i < 5; i++) chk("t3 done id", dn(i), gr(i));
    chk("t3 len", ln(2), 2);
    settle();

    // abort at cycle 10 of a 100-cycle dwell on channel 1
    do_reset();
    cfg(1, 100);
    clr();
    req = 4'b0001; run = 1'b1;
    wait_done(1, 40);
    req = 4'b0010;
    wait_grant(2, 40);
    repeat (9) tick();
    abort = 1'b1; req = 4'b0011;
    tick();
    abort = 1'b0;
    chk("t4 enable", dmx_enable, 0);
    chk("t4 busy", busy, 0);
    chk("t4 select", dmx_select, 0);
    chk("t4 done", ch_done, 0);
    wait_grant(3, 10);
    chk("t4 aborted len", ln(1), 10);
    chk("t4 regrant", gr(2), 1);
    chk("t4 no done", q_done.size(), 1);
    run = 1'b0; req = 4'b0000; abort = 1'b1;
    tick();
    abort = 1'b0;
    settle();

    // zero dwell, then a write during ACTIVE
    cfg(3, 0);
    clr();
    req = 4'b1000; run = 1'b1;
    wait_len(1, 30);
    chk("t5 grant", gr(0), 3);
    chk("t5 zero len", ln(0), 1);
    settle();
    cfg(0, 10);
    clr();
    req = 4'b0001; run = 1'b1;
    wait_grant(1, 20);
    tick();
    cfg(0, 3);
    wait_len(2, 80);
    chk("t5 old len", ln(0), 10);
    chk("t5 new len", ln(1), 3);
    settle();

    // two channels, dwell 4 each
    do_reset();
    for (int c = 0; c < 4; c++) cfg(c, 4);
    clr();
    req = 4'b0011; run = 1'b1;
    wait_len(2, 60);
    chk("t6 g0", gr(0), 0);
    chk("t6 len0", ln(0), 4);
    chk("t6 gap", gp(0), GAP);
    chk("t6 g1", gr(1), 1);
    chk("t6 len1", ln(1), 4);
    settle();

    // random traffic, model checks every cycle
    for (int t = 0; t < 3000; t++) begin
      run    = ($urandom % 8) != 0;
      req    = 4'($urandom);
      abort  = ($urandom % 60) == 0;
      cfg_we = ($urandom % 6) == 0;
      cfg_addr = 2'($urandom);
      cfg_data = 16'($urandom % 5);
      if (t % 700 == 350) begin
        rst_n = 1'b0;
        #2;
        chk("async enable", dmx_enable, 0);
        chk("async busy", busy, 0);
        chk("async select", dmx_select, 0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    cfg_we = 1'b0; abort = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
